// File: rtl/opcode_issue_queue.sv
// opcode_issue_queue: circular-buffer issue queue holding opcode/operand
// entries. The head entry is presented with a one-hot decoded opcode.
// Push and pop may happen on the same edge. A flush clears the queue but
// keeps the issue counter. Reset clears the queue and the issue counter.
module opcode_issue_queue #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] in_opcode,
  input  logic [7:0] in_A,
  input  logic [7:0] in_B,
  input  logic [7:0] in_C,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_instruction,
  output logic [7:0] out_A,
  output logic [7:0] out_B,
  output logic [7:0] out_C,
  output logic [7:0] issue_count,
  output logic [4:0] level
);

  localparam int                PTR_W     = $clog2(DEPTH);
  localparam logic [4:0]        DEPTH_LVL = 5'(DEPTH);
  localparam logic [PTR_W-1:0]  LAST_PTR  = PTR_W'(DEPTH - 1);

  // Entry storage. It is never reset, because only the pointers and the
  // level decide which slots hold valid data.
  logic [2:0] opcode_mem [DEPTH];
  logic [7:0] a_mem      [DEPTH];
  logic [7:0] b_mem      [DEPTH];
  logic [7:0] c_mem      [DEPTH];

  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [4:0]       level_reg, level_next;
  logic [7:0]       issue_count_reg, issue_count_next;

  logic       push;
  logic       pop;
  logic [2:0] head_opcode;

  // The handshake flags come only from the registered level.
  // This keeps out_ready off any combinational path to in_ready.
  assign in_ready  = (level_reg < DEPTH_LVL);
  assign out_valid = (level_reg != 5'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign level       = level_reg;
  assign issue_count = issue_count_reg;

  // Next-state logic: flush overrides push/pop; pointers wrap at DEPTH-1.
  always_comb begin
    wr_ptr_next      = wr_ptr_reg;
    rd_ptr_next      = rd_ptr_reg;
    level_next       = level_reg;
    issue_count_next = issue_count_reg;
    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      level_next  = 5'd0;
    end else begin
      if (push) begin
        wr_ptr_next = (wr_ptr_reg == LAST_PTR) ? '0 : wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_next      = (rd_ptr_reg == LAST_PTR) ? '0 : rd_ptr_reg + 1'b1;
        issue_count_next = issue_count_reg + 8'd1;
      end
      case ({push, pop})
        2'b10:   level_next = level_reg + 5'd1;
        2'b01:   level_next = level_reg - 5'd1;
        default: level_next = level_reg;
      endcase
    end
  end

  // State register. Reset has priority over flush and over any handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      level_reg       <= 5'd0;
      issue_count_reg <= 8'd0;
    end else begin
      wr_ptr_reg      <= wr_ptr_next;
      rd_ptr_reg      <= rd_ptr_next;
      level_reg       <= level_next;
      issue_count_reg <= issue_count_next;
    end
  end

  // Entry write. A push that coincides with a flush or a reset is dropped.
  always_ff @(posedge clk) begin
    if (push && !flush && !rst) begin
      opcode_mem[wr_ptr_reg] <= in_opcode;
      a_mem[wr_ptr_reg]      <= in_A;
      b_mem[wr_ptr_reg]      <= in_B;
      c_mem[wr_ptr_reg]      <= in_C;
    end
  end

  assign head_opcode = opcode_mem[rd_ptr_reg];

  // One-hot opcode decode for the head entry. It reads zero when empty.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_decode
      assign out_instruction[gi] = out_valid && (head_opcode == 3'(gi));
    end
  endgenerate

  assign out_A = out_valid ? a_mem[rd_ptr_reg] : 8'h00;
  assign out_B = out_valid ? b_mem[rd_ptr_reg] : 8'h00;
  assign out_C = out_valid ? c_mem[rd_ptr_reg] : 8'h00;

endmodule

// File: tb/tb_opcode_issue_queue.sv
// tb_opcode_issue_queue: directed stimulus for the opcode issue queue.
// A queue-based reference model predicts the outputs, and a compare
// process checks them on every falling edge. Literal checks pin key values.
module tb_opcode_issue_queue;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] in_opcode = 3'd0;
  logic [7:0] in_A = 8'h00;
  logic [7:0] in_B = 8'h00;
  logic [7:0] in_C = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_instruction;
  logic [7:0] out_A;
  logic [7:0] out_B;
  logic [7:0] out_C;
  logic [7:0] issue_count;
  logic [4:0] level;

  opcode_issue_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_A(in_A), .in_B(in_B), .in_C(in_C),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instruction(out_instruction),
    .out_A(out_A), .out_B(out_B), .out_C(out_C),
    .issue_count(issue_count), .level(level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] c;
  } entry_t;

  entry_t q[$];
  int     m_issue = 0;
  int     n_cmp = 0;
  int     n_fail = 0;
  bit     check_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // The model applies the rules to the inputs that were present at this edge.
  task automatic model_edge();
    bit do_push;
    bit do_pop;
    entry_t e;
    if (rst) begin
      q.delete();
      m_issue = 0;
    end else if (flush) begin
      q.delete();
    end else begin
      do_push = in_valid && (q.size() < DEPTH);
      do_pop  = out_ready && (q.size() > 0);
      if (do_pop) begin
        void'(q.pop_front());
        m_issue = (m_issue + 1) % 256;
      end
      if (do_push) begin
        e.op = in_opcode; e.a = in_A; e.b = in_B; e.c = in_C;
        q.push_back(e);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic push_one(input logic [2:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic [7:0] c);
    in_valid = 1'b1; in_opcode = op; in_A = a; in_B = b; in_C = c;
    step();
    in_valid = 1'b0;
  endtask

  // Compare the DUT outputs against the model on every falling edge.
  always @(negedge clk) begin
    if (check_en) begin
      chk("level", 32'(level), 32'(q.size()));
      chk("in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
      chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
      chk("issue_count", 32'(issue_count), 32'(m_issue));
      if (q.size() > 0) begin
        chk("out_instruction", 32'(out_instruction), 32'(1) << q[0].op);
        chk("out_A", 32'(out_A), 32'(q[0].a));
        chk("out_B", 32'(out_B), 32'(q[0].b));
        chk("out_C", 32'(out_C), 32'(q[0].c));
      end else begin
        chk("out_instruction_idle", 32'(out_instruction), 32'h0);
        chk("out_abc_idle", {8'h0, out_A, out_B, out_C}, 32'h0);
      end
    end
  end

  initial begin
    logic [7:0] exp_seq [4];
    exp_seq[0] = 8'h80; exp_seq[1] = 8'h40; exp_seq[2] = 8'h20; exp_seq[3] = 8'h10;

    // Reset state
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check_en = 1'b1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_issue", 32'(issue_count), 32'd0);
    chk("rst_instr", 32'(out_instruction), 32'h0);

    // Single push with a one-cycle latency, then held through idle cycles
    out_ready = 1'b0;
    push_one(3'd3, 8'h12, 8'h34, 8'h56);
    chk("lat_valid", 32'(out_valid), 32'd1);
    chk("lat_instr", 32'(out_instruction), 32'h08);
    chk("lat_A", 32'(out_A), 32'h12);
    chk("lat_level", 32'(level), 32'd1);
    for (int i = 0; i < 5; i++) step();
    chk("hold_B", 32'(out_B), 32'h34);
    chk("hold_C", 32'(out_C), 32'h56);

    // Fill to full, an ignored extra push, then drain in order
    flush = 1'b1;
    step();
    flush = 1'b0;
    push_one(3'd7, 8'h01, 8'h02, 8'h03);
    push_one(3'd6, 8'h11, 8'h12, 8'h13);
    push_one(3'd5, 8'h21, 8'h22, 8'h23);
    push_one(3'd4, 8'h31, 8'h32, 8'h33);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_level", 32'(level), 32'd4);
    push_one(3'd1, 8'hEE, 8'hEE, 8'hEE);
    chk("full_ignored_level", 32'(level), 32'd4);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_seq", 32'(out_instruction), 32'(exp_seq[i]));
      step();
    end
    chk("drain_empty", 32'(out_valid), 32'd0);
    chk("drain_issue", 32'(issue_count), 32'd4);
    step();  // an idle pop request on an empty queue changes nothing
    chk("empty_pop_issue", 32'(issue_count), 32'd4);

    // Streaming push and pop together for 20 cycles
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_opcode = 3'(i % 8);
      in_A = 8'(i); in_B = ~8'(i); in_C = 8'(i * 3);
      step();
    end
    chk("stream_level", 32'(level), 32'd1);
    chk("stream_issue", 32'(issue_count), 32'd23);
    in_valid = 1'b0;
    step();
    chk("stream_drain_issue", 32'(issue_count), 32'd24);

    // Flush with a simultaneous push and pop on a 3-entry queue
    out_ready = 1'b0;
    push_one(3'd2, 8'hA1, 8'hA2, 8'hA3);
    push_one(3'd0, 8'hB1, 8'hB2, 8'hB3);
    push_one(3'd1, 8'hC1, 8'hC2, 8'hC3);
    flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk("flush_level", 32'(level), 32'd0);
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_instr", 32'(out_instruction), 32'h0);
    chk("flush_A", 32'(out_A), 32'h0);
    chk("flush_issue", 32'(issue_count), 32'd24);

    // Mixed traffic at varying levels, with wrapping pointers
    for (int i = 0; i < 48; i++) begin
      in_valid  = (i % 3) != 0;
      out_ready = (i % 5) < 2;
      in_opcode = 3'((i * 5) % 8);
      in_A = 8'(i + 8'h40); in_B = 8'(i * 7); in_C = 8'(255 - i);
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) step();
    out_ready = 1'b0;

    // Reset together with flush and a push while holding 2 entries
    push_one(3'd5, 8'h55, 8'h66, 8'h77);
    push_one(3'd6, 8'h88, 8'h99, 8'hAA);
    rst = 1'b1; flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    step();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk("rstmid_level", 32'(level), 32'd0);
    chk("rstmid_issue", 32'(issue_count), 32'd0);
    chk("rstmid_in_ready", 32'(in_ready), 32'd1);
    chk("rstmid_out_valid", 32'(out_valid), 32'd0);

    // Issue counter wrap: 255 pops, then one more
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      in_opcode = 3'(i % 8);
      in_A = 8'(i); in_B = 8'(i + 1); in_C = 8'(i + 2);
      step();
    end
    chk("wrap_255", 32'(issue_count), 32'd255);
    in_valid = 1'b0;
    step();
    chk("wrap_0", 32'(issue_count), 32'd0);
    chk("wrap_empty", 32'(out_valid), 32'd0);

    check_en = 1'b0;
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/opcode_issue_queue.md
OPCODE_ISSUE_QUEUE -- requirements
Module: opcode_issue_queue

Interface
REQ-001 Parameter DEPTH, default 4, meaning queue entries; legal values 2, 4, 8, 16 only.
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 flush  input  1  synchronous queue clear, active-high.
REQ-005 in_valid  input  1  upstream offers an instruction this cycle.
REQ-006 in_ready  output  1  queue can accept an instruction this cycle.
REQ-007 in_opcode  input  3  binary opcode 0-7 (7 = shift-left-add ... 0 = add, same numbering as the functional unit).
REQ-008 in_A, in_B, in_C  input  8 each  operands carried with the opcode.
REQ-009 out_valid  output  1  head entry is presented downstream.
REQ-010 out_ready  input  1  functional unit consumes the head entry this cycle.
REQ-011 out_instruction  output  8  one-hot decode of head opcode.
REQ-012 out_A, out_B, out_C  output  8 each  operands of head entry.
REQ-013 issue_count  output  8  number of completed output handshakes, modulo 256.
REQ-014 level  output  5  current number of occupied entries, 0..DEPTH.

Function
REQ-015 Push occurs on a rising edge with in_valid=1 and in_ready=1; pop occurs on a rising edge with out_valid=1 and out_ready=1.
REQ-016 in_ready SHALL be 1 exactly when level < DEPTH, derived only from registered state (no combinational path from out_ready).
REQ-017 out_valid SHALL be 1 exactly when level > 0, derived only from registered state.
REQ-018 Entries SHALL leave in strict arrival order; storage is a circular buffer with read/write pointers wrapping from DEPTH-1 to 0.
REQ-019 out_instruction SHALL be 8'b1 shifted left by the head opcode (opcode 0 -> 8'h01, opcode 7 -> 8'h80), exactly one bit set whenever out_valid=1.
REQ-020 While out_valid=0, out_instruction, out_A, out_B, out_C SHALL all be 8'h00.
REQ-021 Latency: an entry pushed into an empty queue on edge k SHALL be presented with out_valid=1 immediately after edge k (one cycle, no same-cycle bypass).
REQ-022 Simultaneous push and pop on the same edge SHALL leave level unchanged and advance both pointers; permitted at any level 1..DEPTH-1.
REQ-023 When full, in_valid is ignored; when empty, out_ready is ignored; neither corrupts state.
REQ-024 Presented head outputs SHALL remain stable while out_valid=1 and out_ready=0.
REQ-025 issue_count SHALL increment by 1 on every pop, wrapping 255 -> 0.
REQ-026 flush=1 on an edge SHALL set level to 0 and both pointers to 0, discard any simultaneous push, not count any simultaneous pop, and leave issue_count unchanged.

Reset
REQ-027 rst=1 on an edge SHALL clear level, both pointers and issue_count to 0; rst has priority over flush, push and pop.
REQ-028 Immediately after reset: in_ready=1, out_valid=0, out_instruction=8'h00, out_A/B/C=8'h00, issue_count=0, level=0; storage contents need not be cleared.
REQ-029 Reset asserted mid-operation (queue partially full, handshake in progress) SHALL discard all entries and the in-flight transfer.

Verification
REQ-030 Reset, then push opcode 3 with A=8'h12, B=8'h34, C=8'h56, out_ready=0 -> next cycle out_valid=1, out_instruction=8'h08, operands unchanged and held for 5 idle cycles, level=1.
REQ-031 With out_ready=0 push opcodes 7,6,5,4 (DEPTH=4) -> in_ready=0, level=4; a fifth push is ignored; then out_ready=1 -> out_instruction sequence 8'h80, 8'h40, 8'h20, 8'h10, then out_valid=0, issue_count=4.
REQ-032 Continuous push and pop with both valid/ready held at 1 for 20 cycles, opcodes cycling 0..7 -> level stays 1, pointers wrap, output order matches input, issue_count=19 or 20 per handshakes counted.
REQ-033 Preload issue_count to 255 via 255 pops, then one more pop -> issue_count=0.
REQ-034 Queue holding 3 entries, assert flush together with in_valid=1 and out_ready=1 -> next cycle level=0, out_valid=0, outputs 8'h00, issue_count unchanged.
REQ-035 Queue holding 2 entries, assert rst and flush together with push -> next cycle level=0, issue_count=0, in_ready=1, out_valid=0.
